// File: rtl/pipelined_add_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pipelined_add_pkg -- shared segment sizing and stage record.  Rev 1.0
// ---------------------------------------------------------------------------
package pipelined_add_pkg;

  localparam int MAX_WIDTH = 256;

  // Data fields are sized for the widest legal adder; users read [WIDTH-1:0].
  typedef struct packed {
    logic                 valid;
    logic                 carry;
    logic                 sub;
    logic [MAX_WIDTH-1:0] sum;
    logic [MAX_WIDTH-1:0] a;
    logic [MAX_WIDTH-1:0] b;
  } stage_t;

  function automatic int chunk_w(input int width, input int stages);
    return (width + stages - 1) / stages;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipelined_add_seg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pipelined_add_seg -- one carry-chain segment and its register stage.  Rev 1.0
// ---------------------------------------------------------------------------
module pipelined_add_seg
  import pipelined_add_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 1,
  parameter int IDX    = 0
) (
  input  logic   clk,
  input  logic   rst_n,
  input  stage_t in_rec,
  input  logic   load_ok,
  output stage_t out_rec
);

  localparam int CHUNK = chunk_w(WIDTH, STAGES);
  localparam int LO    = IDX * CHUNK;

  stage_t rec_q;
  stage_t rec_d;
  stage_t calc;

  generate
    if (LO < WIDTH) begin : g_slice
      localparam int SW = ((WIDTH - LO) < CHUNK) ? (WIDTH - LO) : CHUNK;
      logic [SW:0] slice_sum;
      always_comb begin
        slice_sum = {1'b0, in_rec.a[LO +: SW]} + {1'b0, in_rec.b[LO +: SW]}
                  + {{SW{1'b0}}, in_rec.carry};
        calc              = in_rec;
        calc.sum[LO +: SW] = slice_sum[SW-1:0];
        calc.carry        = slice_sum[SW];
      end
    end else begin : g_empty
      // Trailing segment beyond the operand width just forwards the record.
      always_comb begin
        calc = in_rec;
      end
    end
  endgenerate

  always_comb begin
    rec_d = rec_q;
    if (load_ok) begin
      if (in_rec.valid) begin
        rec_d = calc;
      end else begin
        rec_d.valid = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rec_q <= '0;
    end else begin
      rec_q <= rec_d;
    end
  end

  assign out_rec = rec_q;

endmodule
`default_nettype wire

// File: rtl/pipelined_add.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pipelined_add -- valid/ready adder/subtractor with STAGES carry segments.  Rev 1.0
// ---------------------------------------------------------------------------
module pipelined_add
  import pipelined_add_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             carry_out,
  output logic             overflow
);

  stage_t p0_q;
  stage_t p0_d;
  stage_t rec [STAGES+1];

  logic [STAGES:0] vld;
  logic [STAGES:0] load_ok;

  assign rec[0] = p0_q;

  // A stage may load when out_ready is high or any stage from it downstream
  // is empty; this is the unrolled form of the ready chain.
  generate
    for (genvar k = 0; k <= STAGES; k++) begin : g_ready
      assign vld[k]     = rec[k].valid;
      assign load_ok[k] = out_ready | ~(&vld[STAGES:k]);
    end
  endgenerate

  assign in_ready = load_ok[0];

  always_comb begin
    p0_d = p0_q;
    if (in_ready) begin
      if (in_valid) begin
        p0_d                = '0;
        p0_d.valid          = 1'b1;
        p0_d.carry          = sub;
        p0_d.sub            = sub;
        p0_d.a[WIDTH-1:0]   = x;
        p0_d.b[WIDTH-1:0]   = sub ? ~y : y;
      end else begin
        p0_d.valid = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p0_q <= '0;
    end else begin
      p0_q <= p0_d;
    end
  end

  generate
    for (genvar i = 0; i < STAGES; i++) begin : g_seg
      pipelined_add_seg #(
        .WIDTH  (WIDTH),
        .STAGES (STAGES),
        .IDX    (i)
      ) u_seg (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_rec  (rec[i]),
        .load_ok (load_ok[i+1]),
        .out_rec (rec[i+1])
      );
    end
  endgenerate

  assign out_valid = rec[STAGES].valid;
  assign out       = rec[STAGES].sum[WIDTH-1:0];
  assign carry_out = rec[STAGES].carry;
  assign overflow  = (rec[STAGES].a[WIDTH-1] == rec[STAGES].b[WIDTH-1]) &&
                     (rec[STAGES].sum[WIDTH-1] != rec[STAGES].a[WIDTH-1]);

  // Consumed operand bits and the sub flag are dead at the last stage.
  logic unused_last;
  assign unused_last = ^rec[STAGES];

endmodule
`default_nettype wire
